// File: rtl/alu_arbiter_8.sv
// Round-robin 8-way ALU operand-port arbiter; grant registered one edge after req seen in IDLE, at least one dead cycle between grants.
// No backpressure: a grant is held until done, requester withdrawal, or MAX_HOLD cycles, then force-released with a timeout pulse.
module alu_arbiter_8 #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 15
) (
    input  logic       i_clk,
    input  logic       i_rstb,
    input  logic [7:0] i_req,
    input  logic       i_done,
    output logic [7:0] o_grant,
    output logic [2:0] o_owner,
    output logic [2:0] o_sel,
    output logic       o_busy,
    output logic       o_timeout
);

    generate
        if (WIDTH < 1 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
            $error("alu_arbiter_8: WIDTH must be >= 1 and MAX_HOLD in 1..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_grant;
    logic [2:0] r_owner;
    logic [2:0] r_ptr;
    logic [7:0] r_hold;
    logic       r_busy;
    logic       r_timeout;

    logic [2:0] w_winner;
    logic       w_any_req;
    logic       w_limit;
    logic       w_release;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_winner = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (i_req[r_ptr + 3'(i)]) begin
                w_winner = r_ptr + 3'(i);
            end
        end
    end

    assign w_any_req = |i_req;
    assign w_limit   = (r_hold == HOLD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_release = i_done | ~i_req[r_owner] | w_limit;
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            r_state   <= S_IDLE;
            r_grant   <= 8'h00;
            r_owner   <= 3'd0;
            r_ptr     <= 3'd0;
            r_hold    <= 8'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Timeout only when the hold limit is the sole release cause.
            r_timeout <= (r_state == S_BUSY) & w_limit & ~i_done & i_req[r_owner];
            if (r_state == S_IDLE) begin
                if (w_any_req) begin
                    r_grant <= 8'h01 << w_winner;
                    r_owner <= w_winner;
                    r_busy  <= 1'b1;
                    r_hold  <= 8'd0;
                end
            end else begin
                r_hold <= r_hold + 8'd1;
                if (w_release) begin
                    r_grant <= 8'h00;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_owner + 3'd1;
                end
            end
        end
    end

    assign o_grant   = r_grant;
    assign o_owner   = r_owner;
    assign o_sel     = {r_owner[1:0], r_owner[2]};
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_alu_arbiter_8.sv
// Directed bench for alu_arbiter_8 with a cycle-level reference model and literal spot checks.
module tb_alu_arbiter_8;

    localparam int MAX_HOLD = 15;

    logic       clk = 1'b0;
    logic       rstb;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] owner;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    alu_arbiter_8 #(.WIDTH(32), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk    (clk),
        .i_rstb   (rstb),
        .i_req    (req),
        .i_done   (done),
        .o_grant  (grant),
        .o_owner  (owner),
        .o_sel    (sel),
        .o_busy   (busy),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks who holds the port and for how many cycles it has been held.
    bit m_busy    = 1'b0;
    bit m_timeout = 1'b0;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_cycles  = 0;

    always @(posedge clk) begin
        if (!rstb) begin
            m_busy = 0; m_timeout = 0; m_owner = 0; m_ptr = 0; m_cycles = 0;
        end else if (m_busy) begin
            m_timeout = 0;
            if (done || !req[m_owner] || m_cycles == MAX_HOLD) begin
                m_timeout = (m_cycles == MAX_HOLD) && !done && req[m_owner];
                m_busy    = 0;
                m_ptr     = (m_owner + 1) % 8;
            end else begin
                m_cycles++;
            end
        end else begin
            m_timeout = 0;
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && req[(m_ptr + k) % 8]) begin
                    m_owner  = (m_ptr + k) % 8;
                    m_busy   = 1;
                    m_cycles = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_grant;
        exp_grant = m_busy ? 8'(1 << m_owner) : 8'h00;
        chk("model_grant",   32'(grant),   32'(exp_grant));
        chk("model_owner",   32'(owner),   32'(m_owner));
        chk("model_sel",     32'(sel),     32'((m_owner % 4) * 2 + m_owner / 4));
        chk("model_busy",    32'(busy),    32'(m_busy));
        chk("model_timeout", 32'(timeout), 32'(m_timeout));
    end

    // Called at a negedge inside the first busy cycle: pulse done, expect a dead cycle, move on.
    task automatic serve(input int exp_owner);
        chk("serve_owner", 32'(owner), 32'(exp_owner));
        chk("serve_busy", 32'(busy), 32'd1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("serve_dead_cycle", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rstb = 1'b0; req = 8'hFF; done = 1'b0;

        // Reset held two cycles with every requester active
        repeat (2) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_sel", 32'(sel), 32'h0);
            chk("rst_timeout", 32'(timeout), 32'h0);
        end
        rstb = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(grant), 32'h01);
        chk("post_rst_owner", 32'(owner), 32'h0);
        chk("post_rst_sel", 32'(sel), 32'h0);

        // Rotation 0..7,0 with literal select encodings
        for (int i = 0; i <= 8; i++) begin
            if (i == 5) chk("sel_owner5", 32'(sel), 32'b011);
            if (i == 3) chk("sel_owner3", 32'(sel), 32'b110);
            serve(i % 8);
        end
        for (int i = 1; i <= 5; i++) serve(i);

        // Owner 6 releases, then only requesters 0 and 2 remain
        chk("owner6", 32'(owner), 32'd6);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h05;
        @(negedge clk);
        chk("wrap_owner0", 32'(owner), 32'd0);
        chk("wrap_grant0", 32'(grant), 32'h01);
        serve(0);
        chk("skip_owner2", 32'(owner), 32'd2);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        @(negedge clk);
        chk("idle_no_req", 32'(busy), 32'd0);

        // Hold limit with a lone requester
        req = 8'h08;
        @(negedge clk);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_busy_len", 32'(n), 32'd15);
        chk("timeout_pulse", 32'(timeout), 32'd1);
        @(negedge clk);
        chk("regrant_owner3", 32'(owner), 32'd3);
        chk("regrant_busy", 32'(busy), 32'd1);
        chk("timeout_one_cycle", 32'(timeout), 32'd0);

        // done coinciding with the limit suppresses the timeout pulse
        repeat (14) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("coinc_done_busy", 32'(busy), 32'd0);
        chk("coinc_done_timeout", 32'(timeout), 32'd0);

        // Withdrawal in the fourth busy cycle
        @(negedge clk);
        chk("drop_granted", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("drop_still_idle", 32'(busy), 32'd0);

        // Reset while owner 4 holds the port
        req = 8'h10;
        @(negedge clk);
        chk("mid_owner4", 32'(owner), 32'd4);
        rstb = 1'b0;
        req  = 8'h30;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_owner", 32'(owner), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_sel", 32'(sel), 32'h0);
        rstb = 1'b1;
        @(negedge clk);
        chk("post_mid_owner", 32'(owner), 32'd4);
        chk("post_mid_grant", 32'(grant), 32'h10);
        chk("post_mid_sel", 32'(sel), 32'b001);

        req = 8'h00;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
